// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board counter demo: counter width, the seven-
// segment pattern type and the active-low hex glyphs.
// Pattern bit order is {a,b,c,d,e,f,g} (bit 6 = segment a); 0 = segment lit.
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int COUNT_W = 16;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0   = 7'b0000001;
    localparam seg_t SEG_1   = 7'b1001111;
    localparam seg_t SEG_2   = 7'b0010010;
    localparam seg_t SEG_3   = 7'b0000110;
    localparam seg_t SEG_4   = 7'b1001100;
    localparam seg_t SEG_5   = 7'b0100100;
    localparam seg_t SEG_6   = 7'b0100000;
    localparam seg_t SEG_7   = 7'b0001111;
    localparam seg_t SEG_8   = 7'b0000000;
    localparam seg_t SEG_9   = 7'b0000100;
    localparam seg_t SEG_A   = 7'b0001000;
    localparam seg_t SEG_B   = 7'b1100000;
    localparam seg_t SEG_C   = 7'b0110001;
    localparam seg_t SEG_D   = 7'b1000010;
    localparam seg_t SEG_E   = 7'b0110000;
    localparam seg_t SEG_F   = 7'b0111000;
    localparam seg_t SEG_OFF = 7'b1111111;

endpackage : board_pkg

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Purely combinational 4-bit hex value to active-low seven-segment pattern.
// Ports:
//   i_hex  [3:0]  value to display
//   o_seg  [6:0]  pattern {a,b,c,d,e,f,g}, 0 = lit
// -----------------------------------------------------------------------------
module seg7_decoder
    import board_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_seg and no latch is inferred.
        o_seg = SEG_OFF;
        case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : seg7_decoder

// File: rtl/board_top.sv
// -----------------------------------------------------------------------------
// board_top
// Free-running 16-bit counter advanced once every DIV clocks, shown in binary
// on the LEDs and as the low hex digit on a seven-segment display.
// Ports:
//   CLK100MHZ        system clock, rising edge
//   CPU_RESET        asynchronous, active-high reset
//   LED [15:0]       counter value, LED[0] = LSB
//   CA..CG           segments a..g, active-low
//   DP               decimal point, active-low
// Build option:
//   DP_BLINK_EN      when defined, DP is lit while counter[4] is 1; otherwise
//                    DP is tied off (unlit).
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module board_top
    import board_pkg::*;
#(
    parameter int DIV = 100000000
)(
    input  logic               CLK100MHZ,
    input  logic               CPU_RESET,
    output logic [COUNT_W-1:0] LED,
    output logic               CA,
    output logic               CB,
    output logic               CC,
    output logic               CD,
    output logic               CE,
    output logic               CF,
    output logic               CG,
    output logic               DP
);

    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] w_cnt_next;
    seg_t               w_seg_next;
    seg_t               r_seg;

    // With DIV = 1 the prescaler sits at 0, which already equals DIV-1,
    // so the tick is high every cycle.
    assign w_tick     = (r_presc == PRESC_W'(DIV - 1));
    assign w_cnt_next = r_cnt + COUNT_W'(w_tick);

    // Decode the value the counter is about to take, so the registered
    // segments update on the same edge as LED.
    seg7_decoder u_seg7_decoder (
        .i_hex (w_cnt_next[3:0]),
        .o_seg (w_seg_next)
    );

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_seg   <= SEG_0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            r_cnt   <= w_cnt_next;
            r_seg   <= w_seg_next;
        end
    end

    assign LED                      = r_cnt;
    assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;

`ifdef DP_BLINK_EN
    logic r_dp;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= ~w_cnt_next[4];
        end
    end

    assign DP = r_dp;
`else
    assign DP = 1'b1;
`endif

endmodule : board_top

// File: tb/tb_board_top.sv
// -----------------------------------------------------------------------------
// tb_board_top
// Directed bench for board_top. u_dut uses DIV = 4 for timing, digit and reset
// behaviour; u_dut_fast uses DIV = 1 to reach the 16-bit wrap quickly.
// -----------------------------------------------------------------------------
module tb_board_top;

    logic        clk;
    logic        rst;
    logic        rst_fast;

    logic [15:0] led;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic [15:0] led_f;
    logic        ca_f, cb_f, cc_f, cd_f, ce_f, cf_f, cg_f, dp_f;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tbl [16];

    board_top #(.DIV(4)) u_dut (
        .CLK100MHZ (clk),
        .CPU_RESET (rst),
        .LED       (led),
        .CA        (ca),
        .CB        (cb),
        .CC        (cc),
        .CD        (cd),
        .CE        (ce),
        .CF        (cf),
        .CG        (cg),
        .DP        (dp)
    );

    board_top #(.DIV(1)) u_dut_fast (
        .CLK100MHZ (clk),
        .CPU_RESET (rst_fast),
        .LED       (led_f),
        .CA        (ca_f),
        .CB        (cb_f),
        .CC        (cc_f),
        .CD        (cd_f),
        .CE        (ce_f),
        .CF        (cf_f),
        .CG        (cg_f),
        .DP        (dp_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then park on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic exp_dp(input logic [15:0] v);
`ifdef DP_BLINK_EN
        return ~v[4];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [6:0] segs();
        return {ca, cb, cc, cd, ce, cf, cg};
    endfunction

    function automatic logic [6:0] segs_f();
        return {ca_f, cb_f, cc_f, cd_f, ce_f, cf_f, cg_f};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111;
        seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
        seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
        seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
        seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010;
        seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;

        // Reset held for 40 ns, released on a falling edge.
        rst      = 1'b1;
        rst_fast = 1'b1;
        #33;
        check("rst_led",  32'(led),    32'h0000);
        check("rst_seg",  32'(segs()), 32'b0000001);
        check("rst_dp",   32'(dp),     32'h1);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_led", 32'(led), 32'h0000);

        // Count 1..20: old value holds for 3 edges, new value on the 4th edge.
        for (int n = 1; n <= 20; n++) begin
            logic [15:0] prev;
            logic [15:0] cur;
            prev = 16'(n - 1);
            cur  = 16'(n);
            step(3);
            check($sformatf("hold_led_%0d", n), 32'(led),    32'(prev));
            check($sformatf("hold_seg_%0d", n), 32'(segs()), 32'(seg_tbl[prev[3:0]]));
            check($sformatf("hold_dp_%0d",  n), 32'(dp),     32'(exp_dp(prev)));
            step(1);
            check($sformatf("tick_led_%0d", n), 32'(led),    32'(cur));
            check($sformatf("tick_seg_%0d", n), 32'(segs()), 32'(seg_tbl[cur[3:0]]));
            check($sformatf("tick_dp_%0d",  n), 32'(dp),     32'(exp_dp(cur)));
        end

        // Explicit landmarks: 0x000A after 40 edges is already covered above;
        // reset asserted now must clear outputs without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_clr_led", 32'(led),    32'h0000);
        check("async_clr_seg", 32'(segs()), 32'b0000001);
        check("async_clr_dp",  32'(dp),     32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Run to LED = 5 with the prescaler part-way (22 edges), then reset
        // between edges and confirm a full DIV period after release.
        step(22);
        check("mid_pre_led", 32'(led), 32'h0005);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_led", 32'(led),    32'h0000);
        check("mid_rst_seg", 32'(segs()), 32'b0000001);
        @(negedge clk);
        rst = 1'b0;
        step(3);
        check("mid_rel3_led", 32'(led), 32'h0000);
        step(1);
        check("mid_rel4_led", 32'(led),    32'h0001);
        check("mid_rel4_seg", 32'(segs()), 32'b1001111);

        // DIV = 1 instance: tick every cycle, used to reach the 16-bit wrap.
        rst_fast = 1'b0;
        step(1);
        check("fast_first_led", 32'(led_f),    32'h0001);
        check("fast_first_seg", 32'(segs_f()), 32'b1001111);
        step(65534);
        check("wrap_ffff_led", 32'(led_f),    32'hFFFF);
        check("wrap_ffff_seg", 32'(segs_f()), 32'b0111000);
        check("wrap_ffff_dp",  32'(dp_f),     32'(exp_dp(16'hFFFF)));
        step(1);
        check("wrap_0000_led", 32'(led_f),    32'h0000);
        check("wrap_0000_seg", 32'(segs_f()), 32'b0000001);
        check("wrap_0000_dp",  32'(dp_f),     32'h1);
        step(1);
        check("wrap_0001_led", 32'(led_f), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_board_top

// File: doc/board_top.md
BOARD_TOP -- requirements
Module: board_top

Interface
- REQ-001: Parameter DIV, default 100000000, gives the clock cycles per count tick; legal range is DIV >= 1, and DIV = 4 is used in simulation.
- REQ-002: CLK100MHZ  input  1  is the single system clock; all logic is rising-edge triggered.
- REQ-003: CPU_RESET  input  1  is the reset; it is asynchronous and active-high.
- REQ-004: LED  output  16  shows the count value, with LED[0] as the LSB.
- REQ-005: CA, CB, CC, CD, CE, CF, CG  output  1 each  drive seven-segment segments a..g; each is active-low (0 = lit).
- REQ-006: DP  output  1  drives the decimal point; it is active-low.

Function
- REQ-007: The prescaler SHALL count 0..DIV-1 and assert a one-cycle internal tick in the cycle where the count equals DIV-1, then wrap to 0.
- REQ-008: If DIV = 1, the tick SHALL be asserted in every cycle.
- REQ-009: The prescaler width SHALL be $clog2(DIV), with a minimum of 1 bit.
- REQ-010: A 16-bit counter SHALL increment by 1 on each rising edge where tick is high.
- REQ-011: The counter SHALL wrap from 0xFFFF to 0x0000 with no flag and no saturation.
- REQ-012: LED SHALL be a register equal to the counter.
- REQ-013: The segment outputs SHALL be registers loaded with the decode of the next counter value, so LED and segments change on the same edge with zero relative latency.
- REQ-014: The segments SHALL show counter[3:0] as a hex digit.
- REQ-015: Segment encoding, CA..CG order a..g, 0 = lit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- REQ-016: First tick timing: after reset release, the counter SHALL read 1 immediately after the DIV-th rising edge.
- REQ-017: The counter SHALL read N after N*DIV edges.
- REQ-018: No output SHALL glitch: all outputs come directly from flops.

Reset
- REQ-019: CPU_RESET high SHALL clear, immediately and regardless of the clock: prescaler = 0, counter = 0, LED = 0x0000, CA..CG = 0000001 (digit 0), DP = 1.
- REQ-020: Reset asserted mid-count SHALL discard any partial prescaler value; counting restarts from 0 with a full DIV period after release.
- REQ-021: Release of CPU_RESET SHALL be followed by normal operation from the next rising edge.

Configuration
- REQ-022: Macro DP_BLINK_EN defined: DP SHALL be a register equal to the inverse of the next counter[4], so the point is lit during every second group of 16 counts and changes on the same edge as LED.
- REQ-023: Macro DP_BLINK_EN undefined: DP SHALL be constant 1 (off), with no DP logic synthesized.

Structure
- REQ-024: Package board_pkg SHALL hold COUNT_W = 16, the seven-bit segment pattern type, and the 16 SEG_* constants from REQ-015 plus SEG_OFF = 1111111.
- REQ-025: Sub-module seg7_decoder SHALL be a purely combinational 4-bit to 7-bit decoder instantiated once.
- REQ-026: The prescaler, counter and output registers SHALL live in board_top.

Verification (DIV = 4, clock period 10 ns)
- REQ-027: Reset scenario: assert CPU_RESET for 40 ns -> LED = 0x0000, CA..CG = 0000001, DP = 1 during and after reset until the first tick.
- REQ-028: Tick timing scenario: release reset, then 4 edges -> LED = 0x0001, segments = 1001111; after 40 edges -> LED = 0x000A, segments = 0001000.
- REQ-029: Digit rollover scenario: count from 0x000F to 0x0010 -> segments go from 0111000 to 0000001 on the same edge as LED; with DP_BLINK_EN, DP goes from 1 to 0 on that edge.
- REQ-030: Counter wrap scenario: run 65536*4 edges -> LED passes 0xFFFF then 0x0000, segments show 0000001, and DP returns to 1.
- REQ-031: Mid-operation reset scenario: assert CPU_RESET at LED = 0x0005 between edges -> LED = 0 immediately; after release, 4 edges pass before LED = 0x0001.
- REQ-032: Configuration scenario: without DP_BLINK_EN, DP = 1 for the entire run.
